// File: rtl/vred_logic_seq.sv
// Sequencer for the vector logical-reduction datapath (vredand/vredor/vredxor).
// Folds the active, unmasked elements into a seed one element per cycle and returns the scalar under valid/ready.
module vred_logic_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 8,
  parameter int OPSEL_WIDTH = 2,
  parameter int VL_WIDTH    = $clog2(LANES) + 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_vec,
  input  logic [DATA_WIDTH-1:0]       in_scalar,
  input  logic [VL_WIDTH-1:0]         in_vl,
  input  logic [LANES-1:0]            in_mask,
  input  logic [OPSEL_WIDTH-1:0]      in_opSel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        busy
);

  localparam int IDX_WIDTH = $clog2(LANES);

  localparam logic [OPSEL_WIDTH-1:0] OP_CLR = OPSEL_WIDTH'(2'b00);
  localparam logic [OPSEL_WIDTH-1:0] OP_AND = OPSEL_WIDTH'(2'b01);
  localparam logic [OPSEL_WIDTH-1:0] OP_OR  = OPSEL_WIDTH'(2'b10);
  localparam logic [OPSEL_WIDTH-1:0] OP_XOR = OPSEL_WIDTH'(2'b11);

  localparam logic [VL_WIDTH-1:0] VL_MAX = VL_WIDTH'(LANES);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                        state_r;
  state_t                        state_nx_s;
  logic [LANES*DATA_WIDTH-1:0]   vec_r;
  logic [LANES-1:0]              mask_r;
  logic [OPSEL_WIDTH-1:0]        op_r;
  logic [VL_WIDTH-1:0]           vl_r;
  logic [IDX_WIDTH-1:0]          idx_r;
  logic [DATA_WIDTH-1:0]         acc_r;
  logic                          out_valid_r;
  logic [DATA_WIDTH-1:0]         out_data_r;
  logic                          busy_r;

  logic [DATA_WIDTH-1:0]         elems_s [LANES];
  logic [DATA_WIDTH-1:0]         acc_step_s;
  logic [VL_WIDTH-1:0]           vl_eff_s;
  logic                          accept_s;
  logic                          last_s;
  logic                          in_ready_s;

  // One combine step of the reduction; clear wins over the element value.
  function automatic logic [DATA_WIDTH-1:0] combine(
    input logic [OPSEL_WIDTH-1:0] op,
    input logic [DATA_WIDTH-1:0]  a,
    input logic [DATA_WIDTH-1:0]  b
  );
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_CLR:  r = {DATA_WIDTH{1'b0}};
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = {DATA_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_unpack
    assign elems_s[g] = vec_r[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_ready_s = (state_r == IDLE) & ~rst;
  assign accept_s   = in_valid & in_ready_s;
  assign vl_eff_s   = (in_vl > VL_MAX) ? VL_MAX : in_vl;
  assign last_s     = ({{(VL_WIDTH-IDX_WIDTH){1'b0}}, idx_r} == (vl_r - VL_WIDTH'(1)));

  // Masked-off elements still burn a cycle so latency depends only on vl.
  always_comb begin
    acc_step_s = acc_r;
    if (mask_r[idx_r]) begin
      acc_step_s = combine(op_r, acc_r, elems_s[idx_r]);
    end else begin
      acc_step_s = acc_r;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = (vl_eff_s != {VL_WIDTH{1'b0}}) ? RUN : DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, datapath and registered result; the result register is set on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      vec_r       <= {(LANES*DATA_WIDTH){1'b0}};
      mask_r      <= {LANES{1'b0}};
      op_r        <= {OPSEL_WIDTH{1'b0}};
      vl_r        <= {VL_WIDTH{1'b0}};
      idx_r       <= {IDX_WIDTH{1'b0}};
      acc_r       <= {DATA_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            vec_r  <= in_vec;
            mask_r <= in_mask;
            op_r   <= in_opSel;
            vl_r   <= vl_eff_s;
            acc_r  <= in_scalar;
            idx_r  <= {IDX_WIDTH{1'b0}};
            if (vl_eff_s == {VL_WIDTH{1'b0}}) begin
              out_valid_r <= 1'b1;
              out_data_r  <= in_scalar;
            end
          end
        end
        RUN: begin
          acc_r <= acc_step_s;
          idx_r <= idx_r + IDX_WIDTH'(1);
          if (last_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= acc_step_s;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          out_data_r  <= {DATA_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_vred_logic_seq.sv
// Self-checking bench for vred_logic_seq: directed scenarios plus randomized requests
// compared against a loop-based reference of the reduction rules.
module tb_vred_logic_seq;

  localparam int DW  = 32;
  localparam int L   = 8;
  localparam int OPW = 2;
  localparam int VLW = $clog2(L) + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [L*DW-1:0]   in_vec;
  logic [DW-1:0]     in_scalar;
  logic [VLW-1:0]    in_vl;
  logic [L-1:0]      in_mask;
  logic [OPW-1:0]    in_opSel;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              busy;

  int total = 0;
  int bad   = 0;

  vred_logic_seq #(.DATA_WIDTH(DW), .LANES(L), .OPSEL_WIDTH(OPW), .VL_WIDTH(VLW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_scalar(in_scalar), .in_vl(in_vl), .in_mask(in_mask), .in_opSel(in_opSel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: clamp vl, then fold every enabled element in order.
  function automatic logic [DW-1:0] ref_reduce(input logic [L*DW-1:0] vec, input logic [DW-1:0] seed,
                                               input int vl, input logic [L-1:0] mask, input int op);
    logic [DW-1:0] acc = seed;
    int n = (vl > L) ? L : vl;
    for (int i = 0; i < n; i++) begin
      if (mask[i]) begin
        if (op == 0) acc = '0;
        else if (op == 1) acc = acc & vec[i*DW +: DW];
        else if (op == 2) acc = acc | vec[i*DW +: DW];
        else acc = acc ^ vec[i*DW +: DW];
      end
    end
    return acc;
  endfunction

  function automatic int ref_lat(input int vl);
    return ((vl > L) ? L : vl) + 1;
  endfunction

  task automatic drive_req(input logic [L*DW-1:0] vec, input logic [DW-1:0] s, input int vl,
                           input logic [L-1:0] m, input int op);
    in_vec = vec; in_scalar = s; in_vl = VLW'(vl); in_mask = m; in_opSel = OPW'(op);
    in_valid = 1'b1;
  endtask

  // Called #1 after an edge with the DUT idle; returns cycles until out_valid is seen.
  task automatic send_wait(input logic [L*DW-1:0] vec, input logic [DW-1:0] s, input int vl,
                           input logic [L-1:0] m, input int op, output int lat);
    drive_req(vec, s, vl, m, op);
    check_eq("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [L*DW-1:0] v;
  logic [DW-1:0]   exp_d;
  int lat, cnt, vl_r, op_r, stall;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_vec = '0; in_scalar = '0; in_vl = '0; in_mask = '0; in_opSel = '0;
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0; #1;
    check_eq("idle_in_ready", in_ready, 1'b1);

    // 1: AND, out_valid exactly one cycle
    out_ready = 1'b1;
    v = '0; v[0 +: DW] = 32'hF0F0F0F0; v[DW +: DW] = 32'hFF00FF00;
    send_wait(v, 32'hFFFFFFFF, 2, 8'hFF, 1, lat);
    check_eq("t1_lat", lat, 3);
    check_eq("t1_data", out_data, 32'hF000F000);
    @(posedge clk); #1;
    check_eq("t1_one_cycle", out_valid, 1'b0);
    check_eq("t1_data_clear", out_data, 32'h0);
    check_eq("t1_in_ready", in_ready, 1'b1);

    // 2: OR with mask 0x55
    v = '0;
    for (int i = 0; i < L; i++) v[i*DW +: DW] = DW'(1) << i;
    send_wait(v, 32'h0, 8, 8'h55, 2, lat);
    check_eq("t2_lat", lat, 9);
    check_eq("t2_data", out_data, 32'h00000055);
    @(posedge clk); #1;

    // 3: XOR with vl=0, then vl=12 clamped
    send_wait(v, 32'h12345678, 0, 8'hFF, 3, lat);
    check_eq("t3a_lat", lat, 1);
    check_eq("t3a_data", out_data, 32'h12345678);
    @(posedge clk); #1;
    for (int i = 0; i < L; i++) v[i*DW +: DW] = 32'h1;
    send_wait(v, 32'h12345678, 12, 8'hFF, 3, lat);
    check_eq("t3b_lat", lat, 9);
    check_eq("t3b_data", out_data, 32'h12345678);
    @(posedge clk); #1;

    // clear op with vl=0 keeps the seed
    send_wait(v, 32'hCAFEF00D, 0, 8'hFF, 0, lat);
    check_eq("clr_vl0_data", out_data, 32'hCAFEF00D);
    @(posedge clk); #1;

    // 4: backpressure with an ignored second request
    out_ready = 1'b0;
    v = '0; v[0 +: DW] = 32'hF0F0F0F0; v[DW +: DW] = 32'hFF00FF00;
    send_wait(v, 32'hFFFFFFFF, 2, 8'hFF, 1, lat);
    check_eq("t4_lat", lat, 3);
    drive_req('0, 32'h0, 1, 8'hFF, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("t4_hold_valid", out_valid, 1'b1);
      check_eq("t4_hold_data", out_data, 32'hF000F000);
      check_eq("t4_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("t4_released", out_valid, 1'b0);
    check_eq("t4_ready_after", in_ready, 1'b1);
    check_eq("t4_busy_after", busy, 1'b0);

    // 5: reset mid-run
    for (int i = 0; i < L; i++) v[i*DW +: DW] = $urandom;
    drive_req(v, 32'h0, 8, 8'hFF, 2);
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check_eq("t5_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check_eq("t5_in_ready", in_ready, 1'b1);
    check_eq("t5_busy", busy, 1'b0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid || out_data != 32'h0) cnt++;
      @(posedge clk); #1;
    end
    check_eq("t5_no_result", cnt, 0);
    v = '0; v[0 +: DW] = 32'h0000FFFF;
    send_wait(v, 32'hAAAAAAAA, 1, 8'h01, 1, lat);
    check_eq("t5_new_lat", lat, 2);
    check_eq("t5_new_data", out_data, 32'h0000AAAA);
    @(posedge clk); #1;

    // 6: back-to-back, request 2 held pending during request 1's DONE
    for (int i = 0; i < L; i++) v[i*DW +: DW] = $urandom;
    send_wait(v, 32'hFFFFFFFF, 3, 8'hFF, 1, lat);
    check_eq("t6a_lat", lat, 4);
    check_eq("t6a_data", out_data, ref_reduce(v, 32'hFFFFFFFF, 3, 8'hFF, 1));
    for (int i = 0; i < L; i++) v[i*DW +: DW] = $urandom;
    drive_req(v, 32'h0, 3, 8'hFF, 2);
    exp_d = ref_reduce(v, 32'h0, 3, 8'hFF, 2);
    @(posedge clk); #1;
    check_eq("t6_handshake", out_valid, 1'b0);
    check_eq("t6_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("t6b_busy", busy, 1'b1);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("t6b_lat", lat, 4);
    check_eq("t6b_data", out_data, exp_d);
    @(posedge clk); #1;

    // randomized requests with random drain stalls
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < L; i++) v[i*DW +: DW] = $urandom;
      exp_d = $urandom;
      vl_r = $urandom_range(0, 12);
      op_r = $urandom_range(0, 3);
      in_mask = L'($urandom);
      out_ready = 1'b0;
      send_wait(v, exp_d, vl_r, in_mask, op_r, lat);
      check_eq("rnd_lat", lat, ref_lat(vl_r));
      exp_d = ref_reduce(v, exp_d, vl_r, in_mask, op_r);
      check_eq("rnd_data", out_data, exp_d);
      check_eq("rnd_busy", busy, 1'b1);
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        check_eq("rnd_hold", out_data, exp_d);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("rnd_drain", out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
